// File: rtl/aa_filter.sv
// aa_filter: boxcar (moving-average) anti-alias low-pass stage feeding the
// decimator. Averages the last 2^LOG2_TAPS accepted samples using a circular
// sample buffer and a running sum, with one output per accepted input, one
// cycle later.
//
// Optional feature macro: AA_FILTER_ROUND_EN
//   defined   -> round-half-up before the divide-by-N shift
//   undefined -> plain truncating shift
module aa_filter #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_TAPS  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_primed
);

    localparam int N     = 1 << LOG2_TAPS;
    localparam int ACC_W = DATA_WIDTH + LOG2_TAPS;

    // Fill counter value meaning "window full"
    localparam logic [LOG2_TAPS:0] FILL_FULL = (LOG2_TAPS + 1)'(N);

`ifdef AA_FILTER_ROUND_EN
    // Half of one LSB of the shifted result, for round-half-up
    localparam logic [ACC_W:0] ROUND_TERM = (ACC_W + 1)'(1) << (LOG2_TAPS - 1);
`endif

    // Divide the running sum by N. With rounding enabled the add is done one
    // bit wider so a full-scale sum plus the rounding term cannot wrap.
    function automatic logic [DATA_WIDTH-1:0] scale_sum(input logic [ACC_W-1:0] sum);
`ifdef AA_FILTER_ROUND_EN
        logic [ACC_W:0] widened;
        widened = {1'b0, sum} + ROUND_TERM;
        return DATA_WIDTH'(widened >> LOG2_TAPS);
`else
        return DATA_WIDTH'(sum >> LOG2_TAPS);
`endif
    endfunction

    logic [DATA_WIDTH-1:0] samp_buf_q [N];
    logic [DATA_WIDTH-1:0] samp_buf_d [N];
    logic [LOG2_TAPS-1:0]  wr_ptr_q;
    logic [LOG2_TAPS-1:0]  wr_ptr_d;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      acc_d;
    logic [LOG2_TAPS:0]    fill_q;
    logic [LOG2_TAPS:0]    fill_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  primed_q;
    logic                  primed_d;

    // Next-state: on an accepted sample replace the oldest buffer entry, update
    // the running sum and emit the new average; otherwise hold everything.
    always_comb begin
        samp_buf_d = samp_buf_q;
        wr_ptr_d   = wr_ptr_q;
        acc_d      = acc_q;
        fill_d     = fill_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        primed_d   = primed_q;

        if (i_valid) begin
            // The buffer entry being overwritten is exactly the sample leaving
            // the window (zero during warm-up), so the sum never needs a rescan.
            acc_d                = acc_q + ACC_W'(i_data) - ACC_W'(samp_buf_q[wr_ptr_q]);
            samp_buf_d[wr_ptr_q] = i_data;
            // Pointer is exactly LOG2_TAPS bits wide, so N-1 wraps to 0 naturally
            wr_ptr_d             = wr_ptr_q + LOG2_TAPS'(1);

            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + (LOG2_TAPS + 1)'(1);
            end else begin
                fill_d = fill_q;
            end

            primed_d = (fill_d == FILL_FULL);
            data_d   = scale_sum(acc_d);
            valid_d  = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset clears everything and drops any
    // sample presented in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                samp_buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            acc_q    <= '0;
            fill_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            samp_buf_q <= samp_buf_d;
            wr_ptr_q   <= wr_ptr_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            primed_q   <= primed_d;
        end
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_primed = primed_q;

endmodule

// File: tb/tb_aa_filter.sv
// Testbench for aa_filter (DATA_WIDTH=16, LOG2_TAPS=3). A reference model keeps
// the accepted samples since reset in a queue and averages the newest eight
// (missing ones count as zero) with plain integer arithmetic.
module tb_aa_filter;

    localparam int DW = 16;
    localparam int LT = 3;
    localparam int N  = 8;

    logic          i_clk;
    logic          i_rst;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_primed;

    int checks;
    int errors;

    // Reference model state
    int            hist[$];
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_primed;

    aa_filter #(.DATA_WIDTH(DW), .LOG2_TAPS(LT)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_primed (o_primed)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] model_avg();
        longint sum;
        sum = 0;
        foreach (hist[i]) sum += hist[i];
`ifdef AA_FILTER_ROUND_EN
        return DW'((sum + N / 2) / N);
`else
        return DW'(sum / N);
`endif
    endfunction

    // Apply one cycle of inputs, let the edge happen, then update the model
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_rst   = r;
        @(posedge i_clk);
        #1;
        if (r) begin
            hist.delete();
            exp_data   = '0;
            exp_valid  = 1'b0;
            exp_primed = 1'b0;
        end else if (v) begin
            hist.push_back(int'(d));
            if (hist.size() > N) void'(hist.pop_front());
            exp_data   = model_avg();
            exp_valid  = 1'b1;
            exp_primed = (hist.size() == N);
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 16'd1234, 1'b1);
        drive(1'b0, 16'd0, 1'b1);
        checks++;
        if ({o_valid, o_primed, o_data} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset: got valid=%0b primed=%0b data=%0d, want 0 0 0", o_valid, o_primed, o_data);
        end
    endtask

    task automatic test_warmup();
        logic [DW-1:0] want;
        drive(1'b0, 16'd0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 16'd800, 1'b0);
`ifdef AA_FILTER_ROUND_EN
            want = DW'((800 * k + 4) / 8);
`else
            want = DW'(800 * k / 8);
`endif
            checks++;
            if (o_data !== want || o_valid !== 1'b1 || o_primed !== (k == 8)) begin
                errors++;
                $display("FAIL warmup k=%0d: got data=%0d valid=%0b primed=%0b, want data=%0d valid=1 primed=%0b",
                         k, o_data, o_valid, o_primed, want, (k == 8));
            end
        end
    endtask

    task automatic test_step_down();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 16'd0, 1'b0);
            checks++;
            if (o_data !== DW'(800 - 100 * k) || o_primed !== 1'b1 || o_data !== exp_data) begin
                errors++;
                $display("FAIL step_down k=%0d: got data=%0d primed=%0b, want data=%0d primed=1",
                         k, o_data, o_primed, 800 - 100 * k);
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic [DW-1:0] held;
        drive(1'b1, 16'd400, 1'b0);
        drive(1'b1, 16'd1000, 1'b0);
        held = exp_data;
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, DW'($urandom), 1'b0);
            checks++;
            if (o_valid !== 1'b0 || o_data !== held) begin
                errors++;
                $display("FAIL gap%0d: got valid=%0b data=%0d, want valid=0 data=%0d", g, o_valid, o_data, held);
            end
        end
        drive(1'b1, 16'd2400, 1'b0);
        checks++;
        if ({o_valid, o_primed, o_data} !== {exp_valid, exp_primed, exp_data}) begin
            errors++;
            $display("FAIL gap_resume: got valid=%0b primed=%0b data=%0d, want %0b %0b %0d",
                     o_valid, o_primed, o_data, exp_valid, exp_primed, exp_data);
        end
    endtask

    task automatic test_full_scale();
        drive(1'b0, 16'd0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 16'hFFFF, 1'b0);
            checks++;
            if ({o_valid, o_primed, o_data} !== {exp_valid, exp_primed, exp_data}
                || (k >= 8 && o_data !== 16'hFFFF)) begin
                errors++;
                $display("FAIL full_scale k=%0d: got valid=%0b primed=%0b data=%0d, want %0b %0b %0d",
                         k, o_valid, o_primed, o_data, exp_valid, exp_primed, exp_data);
            end
        end
    endtask

    task automatic test_rounding();
        logic [DW-1:0] want4;
`ifdef AA_FILTER_ROUND_EN
        want4 = 16'd1;
`else
        want4 = 16'd0;
`endif
        drive(1'b0, 16'd0, 1'b1);
        drive(1'b1, 16'd4, 1'b0);
        checks++;
        if (o_data !== want4 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL round4: got data=%0d valid=%0b, want data=%0d valid=1", o_data, o_valid, want4);
        end
        drive(1'b0, 16'd0, 1'b1);
        drive(1'b1, 16'd3, 1'b0);
        checks++;
        if (o_data !== 16'd0 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL round3: got data=%0d valid=%0b, want data=0 valid=1", o_data, o_valid);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 16'd0, 1'b1);
        for (int k = 0; k < 5; k++) drive(1'b1, 16'd800, 1'b0);
        drive(1'b1, 16'd800, 1'b1);
        checks++;
        if ({o_valid, o_primed, o_data} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL mid_reset_edge: got valid=%0b primed=%0b data=%0d, want 0 0 0", o_valid, o_primed, o_data);
        end
        drive(1'b1, 16'd800, 1'b0);
        checks++;
        if ({o_valid, o_primed, o_data} !== {1'b1, 1'b0, 16'd100}) begin
            errors++;
            $display("FAIL mid_reset_first: got valid=%0b primed=%0b data=%0d, want 1 0 100", o_valid, o_primed, o_data);
        end
    endtask

    task automatic test_random();
        logic          v;
        logic          r;
        logic [DW-1:0] d;
        int            bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 99) < 2);
            d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : DW'($urandom);
            drive(v, d, r);
            checks++;
            if ({o_valid, o_primed, o_data} !== {exp_valid, exp_primed, exp_data}) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random c=%0d: got valid=%0b primed=%0b data=%0d, want %0b %0b %0d",
                             c, o_valid, o_primed, o_data, exp_valid, exp_primed, exp_data);
                bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 16'd0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            drive(1'b1, DW'($urandom), 1'b0);
            checks++;
            if ({o_valid, o_primed, o_data} !== {exp_valid, exp_primed, exp_data}) begin
                errors++;
                $display("FAIL back_to_back c=%0d: got valid=%0b primed=%0b data=%0d, want %0b %0b %0d",
                         c, o_valid, o_primed, o_data, exp_valid, exp_primed, exp_data);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_data     = '0;
        exp_data   = '0;
        exp_valid  = 1'b0;
        exp_primed = 1'b0;

        test_reset();
        test_warmup();
        test_step_down();
        test_valid_gaps();
        test_full_scale();
        test_rounding();
        test_mid_reset();
        test_back_to_back();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
